// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences one single-ported unified RAM between three requesters: the host
//   loader (ld), the data stage (dm) and the fetch stage (im). One access is in
//   flight at a time. Writes complete in their grant cycle. Reads hold the port
//   until the RAM returns data RD_LATENCY cycles later.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   ld_en                         load mode: only the loader is served
//   ld_req/ld_addr/ld_wdata       loader write request, ld_gnt accepts it
//   dm_req/dm_we/dm_addr/dm_wdata data-stage request, dm_gnt accepts it
//   dm_rvalid/dm_rdata            data-stage read return
//   im_req/im_addr                fetch request, im_gnt accepts it
//   im_rvalid/im_rdata            fetch read return
//   if_stall, mem_stall           hold fetch / memory stage until access completes
//   cpu_hold                      registered ld_en, holds the pipeline
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           RAM port
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_en,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic              im_gnt,
  output logic              im_rvalid,
  output logic [DATA_W-1:0] im_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              cpu_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(RD_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {OWN_DM, OWN_IM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              hold_q;
  logic              im_wins;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_DM;
      cnt_q    <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      hold_q   <= ld_en;
    end
  end

  // im only overrides dm once the starvation counter has reached its limit.
  assign im_wins = im_req & (~dm_req | (starve_q == STV_MAX));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    ld_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    im_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    im_rvalid = 1'b0;
    dm_rdata  = '0;
    im_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    // Outputs are forced idle while reset is high; the state register is
    // cleared on the same edge, so an in-flight read never returns.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (ld_en) begin
            if (ld_req) begin
              ld_gnt    = 1'b1;
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = ld_addr;
              mem_wdata = ld_wdata;
            end
          end else if (dm_req && !im_wins) begin
            dm_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_we   = dm_we;
            mem_addr = dm_addr;
            if (dm_we) begin
              mem_wdata = dm_wdata;
            end else begin
              state_d = WAIT;
              owner_d = OWN_DM;
              cnt_d   = LAT_M1;
            end
            if (im_req) begin
              if (starve_q != STV_MAX) starve_d = starve_q + 1'b1;
            end else begin
              starve_d = '0;
            end
          end else if (im_req) begin
            im_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = im_addr;
            state_d  = WAIT;
            owner_d  = OWN_IM;
            cnt_d    = LAT_M1;
            starve_d = '0;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            if (owner_q == OWN_DM) begin
              dm_rvalid = 1'b1;
              dm_rdata  = mem_rdata;
            end else begin
              im_rvalid = 1'b1;
              im_rdata  = mem_rdata;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign if_stall  = im_req & ~im_rvalid;
  assign mem_stall = dm_req & ~(dm_we ? dm_gnt : dm_rvalid);
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_en, ld_req, dm_req, dm_we, im_req;
  logic [31:0] ld_addr, ld_wdata, dm_addr, dm_wdata, im_addr;

  // DUT A: RD_LATENCY=2, STARVE_LIMIT=4
  logic        ld_gnt, dm_gnt, dm_rvalid, im_gnt, im_rvalid;
  logic        if_stall, mem_stall, cpu_hold, mem_en, mem_we;
  logic [31:0] dm_rdata, im_rdata, mem_addr, mem_wdata, mem_rdata;

  // DUT B: RD_LATENCY=3, constant RAM word
  logic        b_ld_gnt, b_dm_gnt, b_dm_rvalid, b_im_gnt, b_im_rvalid;
  logic        b_if_stall, b_mem_stall, b_cpu_hold, b_mem_en, b_mem_we;
  logic [31:0] b_dm_rdata, b_im_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
    .clock(clock), .reset(reset),
    .ld_en(ld_en), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall), .cpu_hold(cpu_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clock(clock), .reset(reset),
    .ld_en(ld_en), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(b_ld_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(b_dm_gnt),
    .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(b_im_gnt), .im_rvalid(b_im_rvalid), .im_rdata(b_im_rdata),
    .if_stall(b_if_stall), .mem_stall(b_mem_stall), .cpu_hold(b_cpu_hold),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // RAM model for DUT A: data captured on the read edge, presented 2 cycles after mem_en.
  logic [31:0] ram [0:255];
  logic [31:0] rpipe0, rpipe1;
  always @(posedge clock) begin
    if (mem_en && mem_we) ram[mem_addr[9:2]] <= mem_wdata;
    rpipe0 <= (mem_en && !mem_we) ? ram[mem_addr[9:2]] : 32'h0BAD0BAD;
    rpipe1 <= rpipe0;
  end
  assign mem_rdata   = rpipe1;
  assign b_mem_rdata = 32'h0000C0DE;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    dm_req = 1'b1; dm_we = 1'b0; im_req = 1'b1;
    #1;
    n_checks++;
    if ({ld_gnt, dm_gnt, im_gnt, dm_rvalid, im_rvalid, mem_en, mem_we, cpu_hold} !== 8'b0) begin
      $display("FAIL reset_ctl: got %b expected %b",
               {ld_gnt, dm_gnt, im_gnt, dm_rvalid, im_rvalid, mem_en, mem_we, cpu_hold}, 8'b0);
      n_fail++;
    end
    n_checks++;
    if ({if_stall, mem_stall} !== 2'b11) begin
      $display("FAIL reset_stalls: got %b expected 11", {if_stall, mem_stall});
      n_fail++;
    end
    n_checks++;
    if ({dm_rdata, im_rdata} !== 64'h0) begin
      $display("FAIL reset_rdata: got %h expected 0", {dm_rdata, im_rdata});
      n_fail++;
    end
    cyc();
    dm_req = 1'b0; im_req = 1'b0; reset = 1'b0;
  endtask

  task automatic test_loader();
    cyc();
    ld_en = 1'b1; ld_req = 1'b1; ld_addr = 32'h0; ld_wdata = 32'hA0000000;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if ({ld_gnt, dm_gnt, mem_en, mem_we} !== 4'b1011) begin
      $display("FAIL ld_first_gnt: got %b expected 1011", {ld_gnt, dm_gnt, mem_en, mem_we});
      n_fail++;
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'hA0000000) begin
      $display("FAIL ld_first_port: got %h/%h expected 0/a0000000", mem_addr, mem_wdata);
      n_fail++;
    end
    for (int i = 1; i < 3; i++) begin
      cyc();
      ld_addr = 32'(4 * i); ld_wdata = 32'hA0000000 + 32'(4 * i);
      #1;
      n_checks++;
      if ({ld_gnt, dm_gnt, mem_we, cpu_hold} !== 4'b1011) begin
        $display("FAIL ld_burst_gnt: got %b expected 1011", {ld_gnt, dm_gnt, mem_we, cpu_hold});
        n_fail++;
      end
      n_checks++;
      if (mem_addr !== 32'(4 * i) || mem_wdata !== 32'hA0000000 + 32'(4 * i)) begin
        $display("FAIL ld_burst_port: got %h/%h expected %h", mem_addr, mem_wdata, 4 * i);
        n_fail++;
      end
    end
    cyc();
    ld_req = 1'b0;
    #1;
    n_checks++;
    if ({ld_gnt, dm_gnt, mem_en, mem_stall} !== 4'b0001) begin
      $display("FAIL ld_dm_ignored: got %b expected 0001", {ld_gnt, dm_gnt, mem_en, mem_stall});
      n_fail++;
    end
    cyc();
    ld_en = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    #1;
    n_checks++;
    if (cpu_hold !== 1'b1) begin
      $display("FAIL cpu_hold_lag: got %b expected 1", cpu_hold);
      n_fail++;
    end
    cyc();
    n_checks++;
    if (cpu_hold !== 1'b0) begin
      $display("FAIL cpu_hold_clear: got %b expected 0", cpu_hold);
      n_fail++;
    end
  endtask

  task automatic test_read_latency();
    cyc();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'h8C010004;
    #1;
    n_checks++;
    if ({dm_gnt, mem_we} !== 2'b11) begin
      $display("FAIL preload_write: got %b expected 11", {dm_gnt, mem_we});
      n_fail++;
    end
    cyc();
    dm_req = 1'b0; dm_we = 1'b0; im_req = 1'b1; im_addr = 32'h10;
    #1;
    n_checks++;
    if ({im_gnt, mem_en, mem_we, if_stall} !== 4'b1101 || mem_addr !== 32'h10) begin
      $display("FAIL rdlat_T: got %b addr %h expected 1101 addr 10",
               {im_gnt, mem_en, mem_we, if_stall}, mem_addr);
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({im_gnt, im_rvalid, mem_en, if_stall} !== 4'b0001 || im_rdata !== 32'h0) begin
      $display("FAIL rdlat_T1: got %b rdata %h expected 0001 rdata 0",
               {im_gnt, im_rvalid, mem_en, if_stall}, im_rdata);
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({im_rvalid, if_stall, dm_rvalid} !== 3'b100 || im_rdata !== 32'h8C010004) begin
      $display("FAIL rdlat_T2: got %b rdata %h expected 100 rdata 8c010004",
               {im_rvalid, if_stall, dm_rvalid}, im_rdata);
      n_fail++;
    end
    cyc();
    im_req = 1'b0;
    #1;
    n_checks++;
    if (mem_en !== 1'b0) begin
      $display("FAIL rdlat_idle: got %b expected 0", mem_en);
      n_fail++;
    end
  endtask

  task automatic test_contention();
    cyc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4; im_req = 1'b1; im_addr = 32'h8;
    #1;
    n_checks++;
    if ({dm_gnt, im_gnt, mem_stall} !== 3'b101 || mem_addr !== 32'h4) begin
      $display("FAIL cont_dm_first: got %b addr %h expected 101 addr 4",
               {dm_gnt, im_gnt, mem_stall}, mem_addr);
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({dm_gnt, im_gnt, dm_rvalid} !== 3'b000) begin
      $display("FAIL cont_wait: got %b expected 000", {dm_gnt, im_gnt, dm_rvalid});
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({dm_rvalid, im_rvalid, mem_stall, im_gnt} !== 4'b1000 || dm_rdata !== 32'hA0000004) begin
      $display("FAIL cont_dm_data: got %b rdata %h expected 1000 rdata a0000004",
               {dm_rvalid, im_rvalid, mem_stall, im_gnt}, dm_rdata);
      n_fail++;
    end
    cyc();
    dm_req = 1'b0;
    #1;
    n_checks++;
    if ({dm_gnt, im_gnt} !== 2'b01 || mem_addr !== 32'h8) begin
      $display("FAIL cont_im_next: got %b addr %h expected 01 addr 8", {dm_gnt, im_gnt}, mem_addr);
      n_fail++;
    end
    cyc(); cyc();
    n_checks++;
    if ({im_rvalid, dm_rvalid} !== 2'b10 || im_rdata !== 32'hA0000008 || dm_rdata !== 32'h0) begin
      $display("FAIL cont_im_data: got %b rdata %h/%h expected 10 rdata a0000008/0",
               {im_rvalid, dm_rvalid}, im_rdata, dm_rdata);
      n_fail++;
    end
    cyc();
    im_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic [5:0] seq;
    int ng;
    logic both, pend;
    seq = '0; ng = 0; both = 1'b0; pend = 1'b0;
    cyc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4; im_req = 1'b1; im_addr = 32'h0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      if (c > 0) cyc();
      else #1;
      if (pend) begin
        pend = 1'b0;
        n_checks++;
        if (u_dut.starve_q !== 3'd0) begin
          $display("FAIL starve_clear: got %0d expected 0", u_dut.starve_q);
          n_fail++;
        end
      end
      if (dm_gnt && im_gnt) both = 1'b1;
      if (dm_gnt || im_gnt) begin
        seq[ng] = im_gnt;
        if (im_gnt) pend = 1'b1;
        ng++;
      end
    end
    cyc();
    dm_req = 1'b0; im_req = 1'b0;
    n_checks++;
    if (ng != 6) begin
      $display("FAIL starve_timeout: got %0d grants expected 6", ng);
      n_fail++;
    end
    n_checks++;
    if (seq !== 6'b010000) begin
      $display("FAIL starve_order: got %b expected 010000 (bit=1 is im, lsb first)", seq);
      n_fail++;
    end
    n_checks++;
    if (both !== 1'b0) begin
      $display("FAIL starve_one_gnt: got %b expected 0", both);
      n_fail++;
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_write_then_read();
    cyc();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({dm_gnt, mem_en, mem_we, mem_stall} !== 4'b1110 || mem_wdata !== 32'hDEADBEEF) begin
      $display("FAIL wr_grant: got %b wdata %h expected 1110 wdata deadbeef",
               {dm_gnt, mem_en, mem_we, mem_stall}, mem_wdata);
      n_fail++;
    end
    cyc();
    dm_we = 1'b0; dm_wdata = 32'h0;
    #1;
    n_checks++;
    if ({dm_gnt, mem_we, mem_stall} !== 3'b101 || mem_addr !== 32'h40) begin
      $display("FAIL rd_after_wr_gnt: got %b addr %h expected 101 addr 40",
               {dm_gnt, mem_we, mem_stall}, mem_addr);
      n_fail++;
    end
    cyc(); cyc();
    n_checks++;
    if ({dm_rvalid, mem_stall} !== 2'b10 || dm_rdata !== 32'hDEADBEEF) begin
      $display("FAIL rd_after_wr_data: got %b rdata %h expected 10 rdata deadbeef",
               {dm_rvalid, mem_stall}, dm_rdata);
      n_fail++;
    end
    cyc();
    dm_req = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    cyc(); cyc(); cyc();
    im_req = 1'b1; im_addr = 32'h0;
    #1;
    n_checks++;
    if (b_im_gnt !== 1'b1) begin
      $display("FAIL rst_mid_first_gnt: got %b expected 1", b_im_gnt);
      n_fail++;
    end
    cyc();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({b_im_gnt, b_im_rvalid, b_mem_en, b_if_stall} !== 4'b0001 || b_im_rdata !== 32'h0) begin
      $display("FAIL rst_mid_during: got %b rdata %h expected 0001 rdata 0",
               {b_im_gnt, b_im_rvalid, b_mem_en, b_if_stall}, b_im_rdata);
      n_fail++;
    end
    cyc();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({b_im_gnt, b_mem_en, b_im_rvalid} !== 3'b110) begin
      $display("FAIL rst_mid_regrant: got %b expected 110", {b_im_gnt, b_mem_en, b_im_rvalid});
      n_fail++;
    end
    cyc();
    n_checks++;
    if (b_im_rvalid !== 1'b0) begin
      $display("FAIL rst_mid_dropped: got %b expected 0", b_im_rvalid);
      n_fail++;
    end
    cyc(); cyc();
    n_checks++;
    if (b_im_rvalid !== 1'b1 || b_im_rdata !== 32'h0000C0DE) begin
      $display("FAIL rst_mid_new_data: got %b rdata %h expected 1 rdata 0000c0de",
               b_im_rvalid, b_im_rdata);
      n_fail++;
    end
    cyc();
    im_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ld_en = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    im_req = 1'b0; im_addr = '0;
    test_reset();
    test_loader();
    test_read_latency();
    test_contention();
    test_starvation();
    test_write_then_read();
    test_reset_mid_read();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
